// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared helpers for the conv unit. Provides the compile-time
//               log2 used to size the adder tree, lane-count and slice-offset
//               helpers for the flattened tree bus, and the saturate/truncate
//               functions used on the output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  // Widest value handled by the saturation helpers; ACC_W must not exceed it.
  localparam int MAX_W = 64;

  // Ceiling log2, usable in localparam context.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Product (lane) width for a given operand width.
  function automatic int pw_of(input int width);
    return 2 * width;
  endfunction

  // Number of lanes entering tree level k: ceil(n / 2^k).
  function automatic int lanes_at(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

  // Bit offset of level k inside the flattened tree bus. Level j holds
  // lanes_at(n, j) lanes, each pw + j bits wide.
  function automatic int level_off(input int n, input int pw, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) begin
      off = off + lanes_at(n, j) * (pw + j);
    end
    return off;
  endfunction

  // Clamp to the signed out_w range when sat_en is set. Otherwise the value
  // is passed through and the caller's width cast performs the wrap.
  function automatic logic signed [MAX_W-1:0] sat_trunc(
    input logic signed [MAX_W-1:0] value,
    input int                      out_w,
    input bit                      sat_en
  );
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (sat_en && (value > hi)) return hi;
    if (sat_en && (value < lo)) return lo;
    return value;
  endfunction

  // High when sat_trunc would clip the value.
  function automatic logic sat_clips(
    input logic signed [MAX_W-1:0] value,
    input int                      out_w,
    input bit                      sat_en
  );
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    return sat_en && ((value > hi) || (value < lo));
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_adder_tree_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_adder_tree_pipe_if
// Description : Beat-in / result-out bundle of the pipelined conv adder tree.
//               Ports: in_valid/in_ready/in_first/in_last/in_data/bias (beat
//               side), out_valid/out_ready/out_data/out_sat (result side).
//               master = producer/consumer around the block, slave = block.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_adder_tree_pipe_if #(
  parameter int NUM_IN = 9,
  parameter int PW     = 18,
  parameter int OUT_W  = 18
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_first;
  logic                   in_last;
  logic [NUM_IN*PW-1:0]   in_data;
  logic [PW-1:0]          bias;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_sat;

  modport master (
    output in_valid, in_first, in_last, in_data, bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last, in_data, bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/adder_tree_stage.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_stage
// Description : One registered reduction level. Adds lane pairs after sign
//               extension by one bit (cannot overflow); an odd last lane is
//               passed through. valid/first/last/bias ride along unchanged.
//               Ports: clk, rst_n, en, in_* (IN_N lanes of IN_W bits),
//               out_* (ceil(IN_N/2) lanes of IN_W+1 bits).
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_stage #(
  parameter  int IN_N   = 9,
  parameter  int IN_W   = 18,
  parameter  int BIAS_W = 18,
  localparam int OUT_N  = (IN_N + 1) / 2,
  localparam int OUT_LW = IN_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [BIAS_W-1:0]       in_bias,
  input  logic [IN_N*IN_W-1:0]    in_data,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic [BIAS_W-1:0]       out_bias,
  output logic [OUT_N*OUT_LW-1:0] out_data
);

  logic [OUT_N*OUT_LW-1:0] sum_c;

  for (genvar i = 0; i < OUT_N; i++) begin : g_pair
    logic signed [IN_W-1:0] lane_a;
    assign lane_a = in_data[2*i*IN_W +: IN_W];
    if (2*i + 1 < IN_N) begin : g_add
      logic signed [IN_W-1:0] lane_b;
      assign lane_b = in_data[(2*i+1)*IN_W +: IN_W];
      assign sum_c[i*OUT_LW +: OUT_LW] = OUT_LW'(lane_a) + OUT_LW'(lane_b);
    end else begin : g_pass
      assign sum_c[i*OUT_LW +: OUT_LW] = OUT_LW'(lane_a);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_bias  <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_first <= in_first;
      out_last  <= in_last;
      out_bias  <= in_bias;
      out_data  <= sum_c;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : conv_adder_tree_pipe
// Description : Pipelined conv adder tree. NUM_IN signed products per beat are
//               reduced over clog2(NUM_IN) registered levels, accumulated over
//               the first..last channel beats with a per-pixel bias, then
//               saturated (or wrapped) to OUT_W and offered on out_*.
//               Ports: clk, rst_n (async, active low), bus (slave modport of
//               conv_adder_tree_pipe_if carrying the beat and result streams).
// Revision    : 1.0 - initial release
// ============================================================================
module conv_adder_tree_pipe
  import conv_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int NUM_IN = 9,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 18,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_adder_tree_pipe_if.slave bus
);

  localparam int PW        = pw_of(WIDTH);
  localparam int L         = clog2(NUM_IN);
  localparam int SUM_W     = PW + L;
  localparam int TREE_BITS = level_off(NUM_IN, PW, L + 1);

  // Single global advance: the whole pipe moves or holds as one.
  logic adv;

  // All tree levels flattened into one bus; level k starts at level_off(k).
  logic [TREE_BITS-1:0] tree;
  logic [L:0]           lv_valid;
  logic [L:0]           lv_first;
  logic [L:0]           lv_last;
  logic [PW-1:0]        lv_bias [0:L];

  logic                    out_valid;
  logic [OUT_W-1:0]        out_data;
  logic                    out_sat;

  assign adv          = !out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_sat   = out_sat;

  assign tree[NUM_IN*PW-1:0] = bus.in_data;
  assign lv_valid[0]         = bus.in_valid;
  assign lv_first[0]         = bus.in_first;
  assign lv_last[0]          = bus.in_last;
  assign lv_bias[0]          = bus.bias;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int IN_N  = lanes_at(NUM_IN, k);
    localparam int IN_W  = PW + k;
    localparam int OUT_N = lanes_at(NUM_IN, k + 1);
    localparam int I_OFF = level_off(NUM_IN, PW, k);
    localparam int O_OFF = level_off(NUM_IN, PW, k + 1);

    adder_tree_stage #(
      .IN_N   (IN_N),
      .IN_W   (IN_W),
      .BIAS_W (PW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .in_valid  (lv_valid[k]),
      .in_first  (lv_first[k]),
      .in_last   (lv_last[k]),
      .in_bias   (lv_bias[k]),
      .in_data   (tree[I_OFF +: IN_N*IN_W]),
      .out_valid (lv_valid[k+1]),
      .out_first (lv_first[k+1]),
      .out_last  (lv_last[k+1]),
      .out_bias  (lv_bias[k+1]),
      .out_data  (tree[O_OFF +: OUT_N*(IN_W+1)])
    );
  end

  // ---------------- accumulate stage ----------------
  logic signed [SUM_W-1:0] tree_sum;
  logic signed [PW-1:0]    tree_bias;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic                    acc_open;
  logic                    acc_done;

  assign tree_sum  = tree[TREE_BITS-1 -: SUM_W];
  assign tree_bias = lv_bias[L];

  // A first beat restarts from the bias (dropping any open partial); a
  // continuation without an open pixel starts from zero and skips the bias.
  always_comb begin
    acc_base = '0;
    if (lv_first[L]) begin
      acc_base = ACC_W'(tree_bias);
    end else if (acc_open) begin
      acc_base = acc;
    end
    acc_next = acc_base + ACC_W'(tree_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      acc_open <= 1'b0;
      acc_done <= 1'b0;
    end else if (adv) begin
      acc_done <= lv_valid[L] && lv_last[L];
      if (lv_valid[L]) begin
        acc      <= acc_next;
        acc_open <= !lv_last[L] && (lv_first[L] || acc_open);
      end
    end
  end

  // ---------------- output stage ----------------
  // When adv is high the previous result is either absent or being taken
  // this cycle, so it may be overwritten without a gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= acc_done;
      if (acc_done) begin
        out_data <= OUT_W'(sat_trunc(MAX_W'(acc), OUT_W, SAT_EN));
        out_sat  <= sat_clips(MAX_W'(acc), OUT_W, SAT_EN);
      end
    end
  end

endmodule
`default_nettype wire
